// File: rtl/neos2test_oci_trace_pkg.sv
// Shared OCI trace constants, the sealed DCT frame layout and the packer state encoding.
package neos2test_oci_trace_pkg;

    localparam int DCT_CODE_W = 2;
    localparam int DCT_DEPTH  = 15;
    localparam int DCT_BUF_W  = 30;
    localparam int DCT_CNT_W  = 4;

    localparam logic [DCT_CNT_W-1:0] DCT_FULL = DCT_CNT_W'(DCT_DEPTH);

    typedef struct packed {
        logic [DCT_CNT_W-1:0] count;
        logic [DCT_BUF_W-1:0] buffer;
    } dct_frame_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } dct_state_e;

    // Writes code into slot idx of the packing buffer, other slots untouched.
    function automatic logic [DCT_BUF_W-1:0] dct_insert(
        input logic [DCT_BUF_W-1:0]  buf_in,
        input logic [DCT_CNT_W-1:0]  idx,
        input logic [DCT_CODE_W-1:0] code
    );
        logic [DCT_BUF_W-1:0] r;
        r = buf_in;
        for (int i = 0; i < DCT_DEPTH; i++) begin
            if (idx == DCT_CNT_W'(i)) r[DCT_CODE_W*i +: DCT_CODE_W] = code;
        end
        return r;
    endfunction

endpackage

// File: rtl/neos2test_nios2_qsys_0_oci_dct_packer_if.sv
// DCT code input and sealed-frame valid/ready channel toward the trace FIFO.
interface neos2test_nios2_qsys_0_oci_dct_packer_if;
    import neos2test_oci_trace_pkg::*;

    logic                  dct_valid;
    logic [DCT_CODE_W-1:0] dct_code;
    logic                  frame_valid;
    logic                  frame_ready;
    dct_frame_t            frame_data;

    modport master (
        input  dct_valid, dct_code, frame_ready,
        output frame_valid, frame_data
    );

    modport slave (
        output dct_valid, dct_code, frame_ready,
        input  frame_valid, frame_data
    );
endinterface

// File: rtl/neos2test_nios2_qsys_0_oci_dct_frame_reg.sv
// One-deep frame holding register; load wins over a same-edge drain, data held while not ready.
module neos2test_nios2_qsys_0_oci_dct_frame_reg
    import neos2test_oci_trace_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  dct_frame_t load_data,
    input  logic       ready,
    output logic       valid,
    output dct_frame_t data
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/neos2test_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT codes into 15-entry frames and hands them to the trace FIFO via valid/ready.
// Optional NEOS2_DCT_DROP_COUNT_EN adds a saturating drop_count output.
module neos2test_nios2_qsys_0_oci_dct_packer
    import neos2test_oci_trace_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    neos2test_nios2_qsys_0_oci_dct_packer_if.master bus,
    input  logic                   flush,
    input  logic                   end_req,
    output logic [DCT_BUF_W-1:0]   dct_buffer,
    output logic [DCT_CNT_W-1:0]   dct_count,
    output logic                   test_ending,
    output logic                   test_has_ended,
`ifdef NEOS2_DCT_DROP_COUNT_EN
    output logic [7:0]             drop_count,
`endif
    output logic                   overflow
);

    dct_state_e           state, state_nx;
    logic                 ending_nx, ended_nx;
    logic                 flush_pend, pend_d;
    logic                 take, full, seal_ok, seal_req, seal, drop;
    logic [DCT_CNT_W-1:0] cnt_nx, cnt_d;
    logic [DCT_BUF_W-1:0] buf_nx, buf_d;
    dct_frame_t           frame_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            state          <= state_nx;
            test_ending    <= ending_nx;
            test_has_ended <= ended_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (end_req) state_nx = DRAIN;
            DRAIN:   if (dct_count == '0 && !bus.frame_valid) state_nx = ENDED;
            ENDED:   state_nx = ENDED;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        ending_nx = (state_nx == DRAIN);
        ended_nx  = (state_nx == ENDED);
    end

    always_comb begin
        take    = bus.dct_valid && (state == RUN);
        full    = (dct_count == DCT_FULL);
        seal_ok = !bus.frame_valid || bus.frame_ready;

        cnt_nx = dct_count;
        buf_nx = dct_buffer;
        if (take && !full) begin
            cnt_nx = dct_count + 4'd1;
            buf_nx = dct_insert(dct_buffer, dct_count, bus.dct_code);
        end

        seal_req = (cnt_nx == DCT_FULL) ||
                   ((cnt_nx != '0) && (flush || flush_pend || state == DRAIN));
        seal     = seal_req && seal_ok;
        drop     = take && full && !seal;
        frame_nx = '{count: cnt_nx, buffer: buf_nx};

        cnt_d  = cnt_nx;
        buf_d  = buf_nx;
        pend_d = flush_pend;
        if (seal) begin
            pend_d = 1'b0;
            // A code arriving while a full buffer is sealed starts the fresh buffer.
            if (take && full) begin
                cnt_d = 4'd1;
                buf_d = {{(DCT_BUF_W-DCT_CODE_W){1'b0}}, bus.dct_code};
            end else begin
                cnt_d = '0;
                buf_d = '0;
            end
        end else if (flush && cnt_nx != '0) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_count  <= '0;
            dct_buffer <= '0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            dct_count  <= cnt_d;
            dct_buffer <= buf_d;
            flush_pend <= pend_d;
            overflow   <= overflow | drop;
        end
    end

`ifdef NEOS2_DCT_DROP_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        drop_count <= 8'd0;
        else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
`endif

    neos2test_nios2_qsys_0_oci_dct_frame_reg u_frame_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (seal),
        .load_data (frame_nx),
        .ready     (bus.frame_ready),
        .valid     (bus.frame_valid),
        .data      (bus.frame_data)
    );

endmodule

// File: tb/tb_neos2test_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer: packing, flush, backpressure/overflow, drain/end and async reset.
module tb_neos2test_nios2_qsys_0_oci_dct_packer;
    import neos2test_oci_trace_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        end_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic        overflow;
`ifdef NEOS2_DCT_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    neos2test_nios2_qsys_0_oci_dct_packer_if bus ();

    neos2test_nios2_qsys_0_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .flush          (flush),
        .end_req        (end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
`ifdef NEOS2_DCT_DROP_COUNT_EN
        .drop_count     (drop_count),
`endif
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code);
        bus.dct_valid = 1'b1;
        bus.dct_code  = code;
        cyc();
        bus.dct_valid = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b1;
        bus.dct_valid   = 1'b0;
        bus.dct_code    = 2'b00;
        bus.frame_ready = 1'b0;
        flush           = 1'b0;
        end_req         = 1'b0;
        #2 reset_n = 1'b0;
        cyc();
        cyc();
        check("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        check("rst_count", 64'(dct_count), 64'd0);
        check("rst_buffer", 64'(dct_buffer), 64'd0);
        check("rst_flags", 64'({test_ending, test_has_ended, overflow}), 64'd0);
        reset_n = 1'b1;
        cyc();

        // 15 back-to-back codes with FIFO ready
        bus.frame_ready = 1'b1;
        send(2'b01);
        check("t1_first_count", 64'(dct_count), 64'd1);
        check("t1_first_buffer", 64'(dct_buffer), 64'h1);
        for (int i = 1; i < 15; i++) send(2'b01);
        check("t1_frame_valid", 64'(bus.frame_valid), 64'd1);
        check("t1_frame_data", 64'(bus.frame_data), 64'({4'd15, 30'h15555555}));
        check("t1_count_cleared", 64'(dct_count), 64'd0);
        check("t1_overflow", 64'(overflow), 64'd0);
        cyc();
        check("t1_frame_taken", 64'(bus.frame_valid), 64'd0);

        // three codes then flush; then an empty flush
        send(2'b11);
        send(2'b10);
        send(2'b01);
        check("t2_count", 64'(dct_count), 64'd3);
        check("t2_buffer", 64'(dct_buffer), 64'h1B);
        flush = 1'b1; cyc(); flush = 1'b0;
        check("t2_frame_valid", 64'(bus.frame_valid), 64'd1);
        check("t2_frame_data", 64'(bus.frame_data), 64'({4'd3, 30'h0000001B}));
        check("t2_count_cleared", 64'(dct_count), 64'd0);
        cyc();
        flush = 1'b1; cyc(); flush = 1'b0;
        check("t2_empty_flush", 64'(bus.frame_valid), 64'd0);
        cyc();
        check("t2_empty_flush_late", 64'(bus.frame_valid), 64'd0);

        // backpressure: 31 codes with FIFO not ready
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(2'b10);
        check("t3_first_frame", 64'(bus.frame_data), 64'({4'd15, 30'h2AAAAAAA}));
        for (int i = 0; i < 15; i++) send(2'b11);
        check("t3_full_count", 64'(dct_count), 64'd15);
        check("t3_no_overflow_yet", 64'(overflow), 64'd0);
        send(2'b01);
        check("t3_frame_stable", 64'(bus.frame_data), 64'({4'd15, 30'h2AAAAAAA}));
        check("t3_frame_held", 64'(bus.frame_valid), 64'd1);
        check("t3_count_held", 64'(dct_count), 64'd15);
        check("t3_buffer_held", 64'(dct_buffer), 64'h3FFFFFFF);
        check("t3_overflow", 64'(overflow), 64'd1);
`ifdef NEOS2_DCT_DROP_COUNT_EN
        check("t3_drop_count", 64'(drop_count), 64'd1);
`endif
        bus.frame_ready = 1'b1;
        cyc();
        check("t3_second_frame", 64'(bus.frame_data), 64'({4'd15, 30'h3FFFFFFF}));
        check("t3_second_valid", 64'(bus.frame_valid), 64'd1);
        check("t3_count_after", 64'(dct_count), 64'd0);
        cyc();
        check("t3_drained", 64'(bus.frame_valid), 64'd0);

        // code and flush in the same cycle at count 4
        for (int i = 0; i < 4; i++) send(2'b01);
        check("t4_count", 64'(dct_count), 64'd4);
        flush = 1'b1;
        send(2'b11);
        flush = 1'b0;
        check("t4_frame_data", 64'(bus.frame_data), 64'({4'd5, 30'h355}));
        check("t4_new_code_bits", 64'(bus.frame_data.buffer[9:8]), 64'd3);
        cyc();

        // end of test at count 6 with FIFO stalled for 5 cycles
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(2'b10);
        check("t5_count", 64'(dct_count), 64'd6);
        end_req = 1'b1; cyc(); end_req = 1'b0;
        check("t5_ending", 64'(test_ending), 64'd1);
        check("t5_not_ended", 64'(test_has_ended), 64'd0);
        for (int i = 0; i < 4; i++) send(2'b11);
        check("t5_frame_pending", 64'(bus.frame_valid), 64'd1);
        check("t5_frame_data", 64'(bus.frame_data), 64'({4'd6, 30'hAAA}));
        check("t5_drain_count", 64'(dct_count), 64'd0);
        check("t5_still_ending", 64'({test_ending, test_has_ended}), 64'b10);
        bus.frame_ready = 1'b1;
        cyc();
        check("t5_frame_taken", 64'(bus.frame_valid), 64'd0);
        cyc();
        check("t5_ended", 64'({test_ending, test_has_ended}), 64'b01);
        for (int i = 0; i < 3; i++) send(2'b01);
        check("t5_codes_ignored", 64'(dct_count), 64'd0);
        check("t5_no_frame", 64'(bus.frame_valid), 64'd0);
        check("t5_overflow_sticky", 64'(overflow), 64'd1);

        // async reset mid-packing with a pending frame
        reset_n = 1'b0; cyc(); reset_n = 1'b1; cyc();
        check("t6_run_again", 64'({test_ending, test_has_ended}), 64'd0);
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(2'b01);
        for (int i = 0; i < 9; i++) send(2'b11);
        check("t6_count9", 64'(dct_count), 64'd9);
        check("t6_pending", 64'(bus.frame_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(bus.frame_valid), 64'd0);
        check("t6_async_data", 64'(bus.frame_data), 64'd0);
        check("t6_async_count", 64'(dct_count), 64'd0);
        check("t6_async_buffer", 64'(dct_buffer), 64'd0);
        check("t6_async_flags", 64'({test_ending, test_has_ended, overflow}), 64'd0);
`ifdef NEOS2_DCT_DROP_COUNT_EN
        check("t6_async_drop_count", 64'(drop_count), 64'd0);
`endif
        cyc();
        reset_n = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
